// File: rtl/mem_master_if.sv
// CPU request/response channels and memory-controller strobe bus of mem_master.
interface mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic        mem_error;

  // Initiator view: takes CPU requests, drives the memory strobes.
  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_error,
    input  resp_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_busy, mem_error
  );

  // Environment view: CPU pipeline plus memory controller.
  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_error,
    output resp_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_busy, mem_error
  );
endinterface

// File: rtl/mem_master.sv
// CPU-side memory bus initiator: one load/store at a time, busy stall with
// timeout, bounded retry on bus error, registered response channel.
module mem_master #(
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 2
) (
  input  logic         clk,
  input  logic         rst,
  mem_master_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic          write_q, write_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_error_q, resp_error_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          gap_q, gap_d;

  // Next-state and next-output logic; every output is registered so it
  // changes only on the clock edge that enters the corresponding state.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    retry_d      = retry_q;
    tmo_d        = tmo_q;
    gap_d        = gap_q;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          if (bus.req_addr[1:0] != 2'b00) begin
            // Misaligned: answer with an error, never touch the bus.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d     = ISSUE;
            write_d     = bus.req_write;
            addr_d      = bus.req_addr;
            wdata_d     = bus.req_wdata;
            retry_d     = '0;
            tmo_d       = '0;
            gap_d       = 1'b0;
            mem_read_d  = !bus.req_write;
            mem_write_d = bus.req_write;
          end
        end
      end

      ISSUE: begin
        if (gap_q) begin
          // One idle cycle between a failed attempt and its re-issue.
          gap_d       = 1'b0;
          mem_read_d  = !write_q;
          mem_write_d = write_q;
        end else if (bus.mem_busy) begin
          if (tmo_q == TMO_LAST) begin
            state_d      = RESP;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = '0;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end else if (bus.mem_error) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            tmo_d   = '0;
            gap_d   = 1'b1;
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = '0;
          end
        end else begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (write_q) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b0;
            resp_rdata_d = '0;
          end else begin
            state_d = RDWAIT;
          end
        end
      end

      RDWAIT: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_error_d = 1'b0;
        resp_rdata_d = bus.mem_rdata;
      end

      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_error_d = 1'b0;
          resp_rdata_d = '0;
          retry_d      = '0;
          tmo_d        = '0;
          req_ready_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      retry_q      <= '0;
      tmo_q        <= '0;
      gap_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      retry_q      <= retry_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_error = resp_error_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;

endmodule
